uart_byte_tx: RTL and testbench

UART_BYTE_TX -- requirements
Module: uart_byte_tx

---
 rtl/uart_defs_pkg.sv | 10 +
 rtl/byte_fifo.sv | 38 +++
 rtl/uart_byte_tx.sv | 81 ++++++++
 tb/tb_uart_byte_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// uart_defs_pkg: UART line definitions shared by the transmitter and the future receiver.
package uart_defs_pkg;
  localparam int CLKS_PER_BIT_DEF = 434;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: first-word fall-through byte FIFO; rd_data is the head whenever empty is low.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign rd_data = mem_q[rd_ptr_q];
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: FIFO-buffered 8N1 UART transmitter, LSB first, idle-high registered line.
module uart_byte_tx
  import uart_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       tx,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  tx_state_e state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, head;
  logic tx_q, overflow_q, busy_q, pop, tick;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(data_valid && !fifo_full),
    .wr_data(data_in),
    .rd_en(pop),
    .rd_data(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign tick = baud_q == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_d = state_q;
    baud_d = (state_q == ST_IDLE || tick) ? '0 : baud_q + CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        pop = 1'b1;
        shift_d = head;
        bit_d = '0;
        state_d = ST_START;
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? ST_STOP : ST_DATA;
      end
      ST_STOP: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // tx and busy follow the state one cycle late, keeping the line glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      overflow_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= (state_q == ST_START) ? 1'b0 : (state_q == ST_DATA) ? shift_q[0] : 1'b1;
      overflow_q <= overflow_q || (data_valid && fifo_full);
      busy_q <= !fifo_empty || state_q != ST_IDLE;
    end
  end
  assign tx = tx_q;
  assign overflow = overflow_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: table-driven and randomized checks of uart_byte_tx against a line decoder and timing model.
module tb_uart_byte_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 16;
  localparam int CHAR = 10 * CPB;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    int k;
    logic tx;
    logic busy;
    logic empty;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, data_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic tx, fifo_full, fifo_empty, overflow, busy;
  int total = 0, bad = 0, cyc = 0, ferr = 0;
  logic line[$];
  bq_t rx;
  uart_byte_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_valid(data_valid),
    .tx(tx),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .overflow(overflow),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) line.push_back(tx);
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Decode the recorded line as 8N1 frames, sampling each bit at its centre.
  task automatic decode();
    int i;
    logic [7:0] b;
    rx.delete();
    ferr = 0;
    i = 0;
    while (i < line.size()) begin
      if (line[i] === 1'b0) begin
        if (i + CHAR - 1 >= line.size()) break;
        for (int j = 0; j < 8; j++) b[j] = line[i + CPB * (j + 1) + CPB / 2];
        if (line[i + CPB / 2] !== 1'b0 || line[i + 9 * CPB + CPB / 2] !== 1'b1) ferr++;
        rx.push_back(b);
        i += CHAR - 1;
      end else i++;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic push(input logic [7:0] b);
    data_in = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || !fifo_empty) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle timeout"}, int'(n < 5000), 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic expect_rx(input string name, input bq_t exp);
    decode();
    check({name, " count"}, rx.size(), exp.size());
    check({name, " framing"}, ferr, 0);
    for (int i = 0; i < exp.size() && i < rx.size(); i++) check($sformatf("%s byte%0d", name, i), rx[i], exp[i]);
  endtask
  initial begin
    vec_t tbl[15];
    bq_t exp, pend;
    int k, last_pop, t;
    logic seen, exp_ovf;
    logic [7:0] csum;
    tbl = '{'{0, 1, 0, 0}, '{1, 1, 1, 1}, '{2, 0, 1, 1}, '{5, 0, 1, 1}, '{7, 1, 1, 1},
            '{11, 0, 1, 1}, '{15, 1, 1, 1}, '{19, 0, 1, 1}, '{23, 0, 1, 1}, '{27, 1, 1, 1},
            '{31, 0, 1, 1}, '{35, 1, 1, 1}, '{38, 1, 1, 1}, '{41, 1, 1, 1}, '{42, 1, 0, 1}};
    @(negedge clk);
    do_reset();
    do_reset();
    check("rst tx", tx, 1);
    check("rst empty", fifo_empty, 1);
    check("rst full", fifo_full, 0);
    check("rst overflow", overflow, 0);
    check("rst busy", busy, 0);
    rst = 1'b1;
    data_in = 8'h77;
    data_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_valid = 1'b0;
    check("rst priority empty", fifo_empty, 1);
    repeat (2) @(negedge clk);
    check("rst priority busy", busy, 0);
    // single byte 0xA5, checked cycle by cycle from the table
    push(8'hA5);
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("a5 tx k=%0d", k), tx, tbl[i].tx);
      check($sformatf("a5 busy k=%0d", k), busy, tbl[i].busy);
      check($sformatf("a5 empty k=%0d", k), fifo_empty, tbl[i].empty);
    end
    // 13-byte frame burst
    do_reset();
    line.delete();
    exp = '{8'h52, 8'h0D, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    csum = '0;
    foreach (exp[i]) csum ^= exp[i];
    exp.push_back(csum);
    exp.push_back(8'h9A);
    foreach (exp[i]) begin
      data_in = exp[i];
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    k = 12;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("frame busy fall", k, 13 * CHAR + 13 + 1);
    repeat (3) @(negedge clk);
    expect_rx("frame", exp);
    check("frame overflow", overflow, 0);
    // 18 consecutive pushes overflow a 16-deep FIFO by one
    do_reset();
    line.delete();
    seen = 1'b0;
    exp.delete();
    for (int i = 0; i < 18; i++) begin
      data_in = 8'(8'h10 + i);
      data_valid = 1'b1;
      if (i < 17) exp.push_back(8'(8'h10 + i));
      @(negedge clk);
      seen |= fifo_full;
    end
    data_valid = 1'b0;
    check("ovf flag", overflow, 1);
    check("ovf full seen", seen, 1);
    wait_idle("ovf");
    expect_rx("ovf", exp);
    check("ovf sticky", overflow, 1);
    // reset during data bit 3 of 0x3C
    do_reset();
    push(8'h3C);
    push(8'h55);
    repeat (18) @(negedge clk);
    check("midrst tx before", tx, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst tx", tx, 1);
    check("midrst empty", fifo_empty, 1);
    check("midrst busy", busy, 0);
    line.delete();
    repeat (100) @(negedge clk);
    k = 0;
    foreach (line[i]) if (line[i] !== 1'b1) k++;
    check("midrst line quiet", k, 0);
    check("midrst busy after", busy, 0);
    // pointer wrap: 40 bytes in bursts of 10
    do_reset();
    line.delete();
    exp.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        data_in = 8'(b * 10 + i);
        data_valid = 1'b1;
        exp.push_back(8'(b * 10 + i));
        @(negedge clk);
      end
      data_valid = 1'b0;
      repeat (400) @(negedge clk);
    end
    wait_idle("wrap");
    expect_rx("wrap", exp);
    check("wrap overflow", overflow, 0);
    // push in the same cycle IDLE pops, with three bytes queued
    do_reset();
    line.delete();
    push(8'hC0);
    repeat (5) @(negedge clk);
    for (int i = 1; i < 4; i++) push(8'(8'hC0 + i));
    check("pp count before", int'(dut.u_fifo.count_q), 3);
    repeat (33) @(negedge clk);
    push(8'hC4);
    check("pp count after", int'(dut.u_fifo.count_q), 3);
    wait_idle("pp");
    expect_rx("pp", '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4});
    check("pp overflow", overflow, 0);
    // random pushes against a timing model: pop edge = max(push+1, previous pop + CHAR + 1)
    do_reset();
    line.delete();
    exp.delete();
    pend.delete();
    exp_ovf = 1'b0;
    last_pop = -100000;
    begin
      int pops[$];
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, (c < 200) ? 2 : 29) == 0) begin
          data_in = 8'($urandom);
          data_valid = 1'b1;
          t = cyc + 1;
          while (pops.size() > 0 && pops[0] < t) void'(pops.pop_front());
          if (pops.size() == DEPTH) exp_ovf = 1'b1;
          else begin
            last_pop = (t + 1 > last_pop + CHAR + 1) ? t + 1 : last_pop + CHAR + 1;
            pops.push_back(last_pop);
            exp.push_back(data_in);
          end
        end else data_valid = 1'b0;
        @(negedge clk);
      end
    end
    data_valid = 1'b0;
    wait_idle("rand");
    expect_rx("rand", exp);
    check("rand overflow", overflow, exp_ovf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
